// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and sequencer phase encoding.
// In this core icode 0 is nop and icode 1 is halt.
package y86_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'h0,
    I_HALT   = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED,
    S_ERROR
  } seq_state_e;

  // Instructions that touch data memory and therefore handshake on the dmem port.
  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

endpackage

// File: rtl/y86_pc_sel.sv
// Combinational next-PC selection for the SEQ core: call/taken jump use valC,
// ret uses the popped return address, everything else falls through to valP.
module y86_pc_sel
  import y86_pkg::*;
(
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic [63:0] valc_i,
  input  logic [63:0] valp_i,
  input  logic [63:0] valm_i,
  output logic [63:0] next_pc_o
);

  always_comb begin
    next_pc_o = valp_i;
    case (icode_i)
      I_CALL:  next_pc_o = valc_i;
      I_JXX:   if (cnd_i) next_pc_o = valc_i;
      I_RET:   next_pc_o = valm_i;
      default: next_pc_o = valp_i;
    endcase
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ core: owns PC and status, steps each instruction
// through F/D/E/M/W/P. Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifun_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valP_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        cnd_i,
  input  logic [63:0] valM_i,
  input  logic        dmem_ready_i,
  input  logic        dmem_error_i,
  output logic [63:0] PC_o,
  output logic        dec_en_o,
  output logic        exe_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        mem_req_o,
  output logic [2:0]  stat_o,
  output logic        busy_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] retire_cnt_o
);

  seq_state_e  state_q, state_d;
  stat_e       stat_q, stat_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;
  logic [63:0] valm_q, valm_d;
  logic        cnd_q, cnd_d;
  logic        mem_req;
  logic [63:0] next_pc;
  logic        unused_ok;

  y86_pc_sel u_pc_sel (
    .icode_i   (icode_q),
    .cnd_i     (cnd_q),
    .valc_i    (valc_q),
    .valp_i    (valp_q),
    .valm_i    (valm_q),
    .next_pc_o (next_pc)
  );

  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    pc_d     = pc_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    valc_d   = valc_q;
    valp_d   = valp_q;
    valm_d   = valm_q;
    cnd_d    = cnd_q;
    dec_en_o = 1'b0;
    exe_en_o = 1'b0;
    mem_en_o = 1'b0;
    wb_en_o  = 1'b0;
    mem_req  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        icode_d = icode_i;
        ifun_d  = ifun_i;
        valc_d  = valC_i;
        valp_d  = valP_i;
        if (imem_error_i) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else if (!instr_valid_i) begin
          state_d = S_ERROR;
          stat_d  = STAT_INS;
        end else if (icode_i == I_HALT) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_en_o = 1'b1;
        state_d  = S_EXECUTE;
      end
      S_EXECUTE: begin
        exe_en_o = 1'b1;
        cnd_d    = cnd_i;
        state_d  = S_MEMORY;
      end
      // Memory instructions park here until the data port answers; a faulting
      // access skips write-back so no architectural state is updated.
      S_MEMORY: begin
        mem_en_o = 1'b1;
        if (is_mem_icode(icode_q)) begin
          mem_req = 1'b1;
          if (dmem_ready_i) begin
            valm_d = valM_i;
            if (dmem_error_i) begin
              state_d = S_ERROR;
              stat_d  = STAT_ADR;
            end else begin
              state_d = S_WRITEBACK;
            end
          end
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        wb_en_o = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_d    = next_pc;
        state_d = S_FETCH;
      end
      S_HALTED, S_ERROR: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      pc_q    <= RESET_PC;
      icode_q <= '0;
      ifun_q  <= '0;
      valc_q  <= '0;
      valp_q  <= '0;
      valm_q  <= '0;
      cnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      valm_q  <= valm_d;
      cnd_q   <= cnd_d;
    end
  end

  // The request is withdrawn in the same cycle reset is raised so memory never sees a stale access.
  assign mem_req_o = mem_req & ~rst_i;
  assign PC_o      = pc_q;
  assign stat_o    = stat_q;
  assign busy_o    = !(state_q inside {S_IDLE, S_HALTED, S_ERROR});

  // ifun and the fetch memory depth are carried for the datapath; the sequencer does not need them.
  assign unused_ok = ^{ifun_q, IMEM_ADDR_W};

`ifdef SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + 64'(busy_o);
    retire_cnt_d = retire_cnt_q + 64'(state_q == S_PCUPD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
`else
  assign cycle_cnt_o  = '0;
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: an instruction-level model predicts every cycle's
// outputs, directed cases pin the model with literal values, then randomized programs run.
module tb_y86_seq_ctrl;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [3:0]  icode_i, ifun_i;
  logic [63:0] valC_i, valP_i, valM_i;
  logic        instr_valid_i, imem_error_i, cnd_i, dmem_ready_i, dmem_error_i;
  logic [63:0] PC_o, cycle_cnt_o, retire_cnt_o;
  logic        dec_en_o, exe_en_o, mem_en_o, wb_en_o, mem_req_o, busy_o;
  logic [2:0]  stat_o;

  y86_seq_ctrl #(.RESET_PC(64'h0), .IMEM_ADDR_W(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .icode_i(icode_i), .ifun_i(ifun_i), .valC_i(valC_i), .valP_i(valP_i),
    .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i), .cnd_i(cnd_i),
    .valM_i(valM_i), .dmem_ready_i(dmem_ready_i), .dmem_error_i(dmem_error_i),
    .PC_o(PC_o), .dec_en_o(dec_en_o), .exe_en_o(exe_en_o), .mem_en_o(mem_en_o),
    .wb_en_o(wb_en_o), .mem_req_o(mem_req_o), .stat_o(stat_o), .busy_o(busy_o),
    .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          chk;
    bit          dec, exe, mem, wb, req, busy;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [63:0] ccnt, rcnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] m_pc, m_ccnt, m_rcnt;
  logic [2:0]  m_stat;
  bit          m_term;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Single compare process: one predicted record per clock cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        checkOutput("dec_en", 64'(dec_en_o), 64'(e.dec));
        checkOutput("exe_en", 64'(exe_en_o), 64'(e.exe));
        checkOutput("mem_en", 64'(mem_en_o), 64'(e.mem));
        checkOutput("wb_en", 64'(wb_en_o), 64'(e.wb));
        checkOutput("mem_req", 64'(mem_req_o), 64'(e.req));
        checkOutput("busy", 64'(busy_o), 64'(e.busy));
        checkOutput("pc", PC_o, e.pc);
        checkOutput("stat", 64'(stat_o), 64'(e.stat));
        checkOutput("cycle_cnt", cycle_cnt_o, e.ccnt);
        checkOutput("retire_cnt", retire_cnt_o, e.rcnt);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic scramble();
    start_i       = 1'($urandom);
    icode_i       = 4'($urandom);
    ifun_i        = 4'($urandom);
    valC_i        = {$urandom, $urandom};
    valP_i        = {$urandom, $urandom};
    valM_i        = {$urandom, $urandom};
    instr_valid_i = 1'($urandom);
    imem_error_i  = 1'($urandom);
    cnd_i         = 1'($urandom);
    dmem_ready_i  = 1'($urandom);
    dmem_error_i  = 1'($urandom);
  endtask

  // Records what the outputs must be during the current cycle, then advances one clock.
  task automatic applyStimulus(input bit dec, exe, mem, wb, req, busy);
    exp_t e;
    e.chk = 1'b1; e.dec = dec; e.exe = exe; e.mem = mem; e.wb = wb; e.req = req; e.busy = busy;
    e.pc = m_pc; e.stat = m_stat;
    e.ccnt = PERF ? m_ccnt : 64'd0;
    e.rcnt = PERF ? m_rcnt : 64'd0;
    exp_q.push_back(e);
    if (busy) m_ccnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic doReset();
    exp_t e;
    scramble();
    rst_i = 1'b1;
    #1;
    checkOutput("mem_req_during_reset", 64'(mem_req_o), 64'd0);
    e.chk = 1'b0;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    rst_i  = 1'b0;
    m_pc   = 64'h0;
    m_stat = 3'd1;
    m_ccnt = 64'd0;
    m_rcnt = 64'd0;
    m_term = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      scramble(); start_i = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic startRun();
    scramble(); start_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic termCycles(input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
  endtask

  // Walks one instruction through its phases, driving the inputs that matter and noise elsewhere.
  task automatic execInstr(input logic [3:0] icode, input logic [63:0] valc, valp, valm,
                           input bit cnd, input int waits, input bit imem_err, valid, dmem_err);
    bit is_mem;
    is_mem = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    scramble();
    icode_i = icode; valC_i = valc; valP_i = valp;
    instr_valid_i = valid; imem_error_i = imem_err;
    applyStimulus(0, 0, 0, 0, 0, 1);
    if (imem_err)       begin m_stat = 3'd3; m_term = 1'b1; return; end
    if (!valid)         begin m_stat = 3'd4; m_term = 1'b1; return; end
    if (icode == 4'h1)  begin m_stat = 3'd2; m_term = 1'b1; return; end
    scramble();
    applyStimulus(1, 0, 0, 0, 0, 1);
    scramble(); cnd_i = cnd;
    applyStimulus(0, 1, 0, 0, 0, 1);
    if (is_mem) begin
      for (int i = 0; i < waits; i++) begin
        scramble(); dmem_ready_i = 1'b0;
        applyStimulus(0, 0, 1, 0, 1, 1);
      end
      scramble(); dmem_ready_i = 1'b1; dmem_error_i = dmem_err; valM_i = valm;
      applyStimulus(0, 0, 1, 0, 1, 1);
      if (dmem_err) begin m_stat = 3'd3; m_term = 1'b1; return; end
    end else begin
      scramble();
      applyStimulus(0, 0, 1, 0, 0, 1);
    end
    scramble();
    applyStimulus(0, 0, 0, 1, 0, 1);
    scramble();
    applyStimulus(0, 0, 0, 0, 0, 1);
    if (icode == 4'h8 || (icode == 4'h7 && cnd)) m_pc = valc;
    else if (icode == 4'h9)                      m_pc = valm;
    else                                         m_pc = valp;
    m_rcnt++;
  endtask

  task automatic randomInstr();
    int          roll;
    logic [3:0]  icode;
    bit          valid, imem_err, dmem_err;
    roll = $urandom_range(0, 99);
    valid = 1'b1; imem_err = 1'b0;
    if (roll < 3)      icode = 4'h1;
    else if (roll < 5) begin icode = 4'($urandom); imem_err = 1'b1; valid = 1'($urandom); end
    else if (roll < 7) begin icode = 4'($urandom_range(12, 15)); valid = 1'b0; end
    else begin
      icode = 4'($urandom_range(1, 11));
      if (icode == 4'h1) icode = 4'h0;
    end
    dmem_err = ($urandom_range(0, 29) == 0);
    execInstr(icode, {$urandom, $urandom}, m_pc + 64'($urandom_range(1, 10)),
              {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 4),
              imem_err, valid, dmem_err);
  endtask

  initial begin
    scramble();
    rst_i = 1'b1; start_i = 1'b0;
    m_pc = '0; m_stat = 3'd1; m_ccnt = '0; m_rcnt = '0; m_term = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // nop then halt from reset
    doReset();
    checkOutput("reset_pc", PC_o, 64'h0);
    checkOutput("reset_stat", 64'(stat_o), 64'd1);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_cycle_cnt", cycle_cnt_o, 64'd0);
    idleCycles(2);
    startRun();
    execInstr(4'h0, 64'h55, 64'h1, 64'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("nop_pc", PC_o, 64'h1);
    checkOutput("nop_retire", retire_cnt_o, PERF ? 64'd1 : 64'd0);
    execInstr(4'h1, 64'h0, 64'h2, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("halt_stat", 64'(stat_o), 64'd2);
    checkOutput("halt_pc", PC_o, 64'h1);
    checkOutput("halt_busy", 64'(busy_o), 64'd0);
    checkOutput("halt_cycle_cnt", cycle_cnt_o, PERF ? 64'd7 : 64'd0);
    scramble(); start_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    termCycles(2);

    // jumps, ret with delayed memory, then an imem fault at 2048
    doReset();
    startRun();
    execInstr(4'h7, 64'h1000, 64'h9, 64'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("jmp_pc", PC_o, 64'h1000);
    execInstr(4'h7, 64'hDEAD, 64'h1D, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("jne_pc", PC_o, 64'h1D);
    execInstr(4'h9, 64'h1234, 64'h1E, 64'h40, 1'b1, 2, 1'b0, 1'b1, 1'b0);
    checkOutput("ret_pc", PC_o, 64'h40);
    execInstr(4'h7, 64'h800, 64'h49, 64'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    execInstr(4'h0, 64'h0, 64'h801, 64'h0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("imem_err_stat", 64'(stat_o), 64'd3);
    checkOutput("imem_err_pc", PC_o, 64'h800);
    termCycles(2);

    // invalid instruction, later start ignored
    doReset();
    startRun();
    execInstr(4'hC, 64'h0, 64'h1, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    scramble(); start_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ins_stat", 64'(stat_o), 64'd4);
    checkOutput("ins_busy", 64'(busy_o), 64'd0);

    // data memory fault on popq
    doReset();
    startRun();
    execInstr(4'hB, 64'h0, 64'h2, 64'h77, 1'b0, 1, 1'b0, 1'b1, 1'b1);
    checkOutput("dmem_err_stat", 64'(stat_o), 64'd3);
    termCycles(2);

    // reset while stalled in MEMORY
    doReset();
    startRun();
    scramble(); icode_i = 4'h8; instr_valid_i = 1'b1; imem_error_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    scramble(); applyStimulus(1, 0, 0, 0, 0, 1);
    scramble(); applyStimulus(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      scramble(); dmem_ready_i = 1'b0;
      applyStimulus(0, 0, 1, 0, 1, 1);
    end
    doReset();
    checkOutput("rst_mem_pc", PC_o, 64'h0);
    checkOutput("rst_mem_stat", 64'(stat_o), 64'd1);
    checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
    checkOutput("rst_mem_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_mem_cycle_cnt", cycle_cnt_o, 64'd0);
    checkOutput("rst_mem_retire_cnt", retire_cnt_o, 64'd0);
    idleCycles(1);

    // randomized programs
    for (int r = 0; r < 25; r++) begin
      doReset();
      idleCycles($urandom_range(0, 2));
      startRun();
      for (int k = 0; k < 30 && !m_term; k++) randomInstr();
      if (m_term) termCycles(3);
    end

    @(negedge clk_i); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
